// File: rtl/multicycle_ctrl_if.sv
// Control bundle between fetch/datapath and the multi-cycle sequencer.
// The sequencer is the slave side; fetch, memory and display form the master side.
interface multicycle_ctrl_if #(
    parameter int RET_W = 16
);
    logic             instr_valid;
    logic [4:0]       opcode;
    logic [1:0]       instr_type;
    logic             mem_ready;
    logic             disp_ready;

    logic             ir_load;
    logic             mem_read_en;
    logic             mem_write_en;
    logic             reg_write_en;
    logic             alu_imm;
    logic             display;
    logic [1:0]       data_to_reg;
    logic             pc_en;
    logic             instr_done;
    logic             illegal;
    logic             bus_error;
    logic             busy;
    logic [RET_W-1:0] retired_count;

    modport slave (
        input  instr_valid, opcode, instr_type, mem_ready, disp_ready,
        output ir_load, mem_read_en, mem_write_en, reg_write_en, alu_imm, display,
               data_to_reg, pc_en, instr_done, illegal, bus_error, busy, retired_count
    );

    modport master (
        output instr_valid, opcode, instr_type, mem_ready, disp_ready,
        input  ir_load, mem_read_en, mem_write_en, reg_write_en, alu_imm, display,
               data_to_reg, pc_en, instr_done, illegal, bus_error, busy, retired_count
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/DISP/WB with registered
// datapath enables, multiply stretching, memory timeout and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int MUL_LATENCY = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int RET_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    multicycle_ctrl_if.slave bus
);
    localparam int CNT_MAX = (MEM_TIMEOUT > MUL_LATENCY) ? MEM_TIMEOUT : MUL_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_DISP, S_WB
    } state_e;

    typedef struct packed {
        logic       is_load;
        logic       is_store;
        logic       is_li;
        logic       is_alu;
        logic       is_mul;
        logic       is_disp;
        logic       disp_mem;
        logic       alu_imm;
        logic       writes;
        logic [1:0] data_to_reg;
    } dec_t;

    typedef struct packed {
        logic       mem_read_en;
        logic       mem_write_en;
        logic       reg_write_en;
        logic       alu_imm;
        logic       display;
        logic [1:0] data_to_reg;
        logic       pc_en;
        logic       instr_done;
        logic       illegal;
        logic       bus_error;
        logic       busy;
    } out_t;

    function automatic dec_t decode(input logic [1:0] itype, input logic [4:0] op);
        dec_t d;
        d          = '0;
        d.is_load  = (itype == 2'b01) && (op == 5'd0);
        d.is_li    = (itype == 2'b01) && (op == 5'd1);
        d.is_store = (itype == 2'b01) && (op == 5'd2);
        d.is_alu   = (itype == 2'b00) && (op >= 5'd3) && (op <= 5'd19);
        d.is_mul   = d.is_alu && (op[4:1] == 4'b0111);
        d.is_disp  = (itype == 2'b11) && (op >= 5'd21) && (op <= 5'd24);
        d.disp_mem = d.is_disp && (op == 5'd23);
        d.alu_imm  = d.is_alu && (op inside {5'd4, 5'd6, 5'd7, 5'd15, 5'd17, 5'd19});
        d.writes   = d.is_load || d.is_li || (d.is_alu && (op <= 5'd15));
        if (d.is_alu && (op <= 5'd15)) d.data_to_reg = 2'b10;
        else if (d.is_load)            d.data_to_reg = 2'b01;
        else if (d.is_li)              d.data_to_reg = 2'b11;
        else                           d.data_to_reg = 2'b00;
        return d;
    endfunction

    state_e           state_q, state_d;
    logic [4:0]       opcode_q, opcode_d;
    logic [1:0]       itype_q, itype_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ill_flag_q, ill_flag_d;
    logic             bus_flag_q, bus_flag_d;
    logic [RET_W-1:0] retired_q, retired_d;
    out_t             out_q, out_d;
    dec_t             dec_d;

    // NOTE: every always_comb target gets a default first, so no path infers a latch.
    always_comb begin
        opcode_d = opcode_q;
        itype_d  = itype_q;
        if ((state_q == S_FETCH) && bus.instr_valid) begin
            opcode_d = bus.opcode;
            itype_d  = bus.instr_type;
        end
    end

    assign dec_d = decode(itype_d, opcode_d);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ill_flag_d = ill_flag_q;
        bus_flag_d = bus_flag_q;
        retired_d  = retired_q;
        case (state_q)
            S_FETCH: if (bus.instr_valid) state_d = S_DECODE;
            S_DECODE: begin
                if (dec_d.is_load || dec_d.is_store) begin
                    state_d = S_MEM;
                    cnt_d   = CNT_W'(1);
                end else if (dec_d.is_alu) begin
                    state_d = S_EXEC;
                    cnt_d   = dec_d.is_mul ? CNT_W'(MUL_LATENCY - 1) : '0;
                end else if (dec_d.is_disp) begin
                    state_d = S_DISP;
                end else begin
                    state_d    = S_WB;
                    ill_flag_d = !dec_d.is_li;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) state_d = S_WB;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            // cnt_q counts the MEM cycle in progress; a late ack still wins over the timeout.
            S_MEM: begin
                if (bus.mem_ready) begin
                    state_d = S_WB;
                end else if ((MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT))) begin
                    state_d    = S_WB;
                    bus_flag_d = 1'b1;
                end else if (MEM_TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DISP: if (bus.disp_ready) state_d = S_WB;
            S_WB: begin
                state_d    = S_FETCH;
                ill_flag_d = 1'b0;
                bus_flag_d = 1'b0;
                retired_d  = retired_q + RET_W'(1);
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs are registered copies of what the next state demands.
    always_comb begin
        out_d              = '0;
        out_d.busy         = (state_d != S_FETCH);
        out_d.mem_read_en  = ((state_d == S_MEM) && dec_d.is_load) ||
                             ((state_d == S_DISP) && dec_d.disp_mem);
        out_d.mem_write_en = (state_d == S_MEM) && dec_d.is_store;
        out_d.display      = (state_d == S_DISP);
        out_d.alu_imm      = out_d.busy && dec_d.alu_imm;
        out_d.data_to_reg  = out_d.busy ? dec_d.data_to_reg : 2'b00;
        out_d.pc_en        = (state_d == S_WB);
        out_d.instr_done   = (state_d == S_WB);
        out_d.illegal      = (state_d == S_WB) && ill_flag_d;
        out_d.bus_error    = (state_d == S_WB) && bus_flag_d;
        out_d.reg_write_en = (state_d == S_WB) && dec_d.writes && !ill_flag_d && !bus_flag_d;
    end

    // NOTE: state uses non-blocking assignments; the async reset clears outputs immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            opcode_q   <= '0;
            itype_q    <= '0;
            cnt_q      <= '0;
            ill_flag_q <= 1'b0;
            bus_flag_q <= 1'b0;
            retired_q  <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            itype_q    <= itype_d;
            cnt_q      <= cnt_d;
            ill_flag_q <= ill_flag_d;
            bus_flag_q <= bus_flag_d;
            retired_q  <= retired_d;
            out_q      <= out_d;
        end
    end

    // ir_load must follow instr_valid within the FETCH cycle, so it is the one combinational output.
    assign bus.ir_load       = !rst && (state_q == S_FETCH) && bus.instr_valid;
    assign bus.mem_read_en   = out_q.mem_read_en;
    assign bus.mem_write_en  = out_q.mem_write_en;
    assign bus.reg_write_en  = out_q.reg_write_en;
    assign bus.alu_imm       = out_q.alu_imm;
    assign bus.display       = out_q.display;
    assign bus.data_to_reg   = out_q.data_to_reg;
    assign bus.pc_en         = out_q.pc_en;
    assign bus.instr_done    = out_q.instr_done;
    assign bus.illegal       = out_q.illegal;
    assign bus.bus_error     = out_q.bus_error;
    assign bus.busy          = out_q.busy;
    assign bus.retired_count = retired_q;
endmodule
